// File: rtl/expander_pkg.sv
// Shared constants for the SPI expander command core: register addresses,
// command-byte layout and command FSM state encoding.
package expander_pkg;

    localparam logic [3:0] ADDR_OUT     = 4'h0;
    localparam logic [3:0] ADDR_MODE    = 4'h1;
    localparam logic [3:0] ADDR_DUTY    = 4'h2;
    localparam logic [3:0] ADDR_CMDCNT  = 4'h3;
    localparam logic [3:0] ADDR_SCRATCH = 4'h4;

    localparam int RW_BIT    = 7;
    localparam int PWM_CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } state_e;

endpackage

// File: rtl/expander_core_pwm_gen.sv
// PWM generator: prescaler divides clk by PWM_DIV, each wrap advances an
// 8-bit ramp which is compared against the duty value.
module pwm_gen
    import expander_pkg::*;
#(
    parameter int PWM_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PWM_CNT_W-1:0] duty,
    output logic                 pwm_bit
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

    logic [PRE_W-1:0]     pre_q;
    logic [PRE_W-1:0]     pre_d;
    logic [PWM_CNT_W-1:0] cnt_q;
    logic [PWM_CNT_W-1:0] cnt_d;

    // Next-state for prescaler and ramp counter
    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (pre_q == PRE_MAX) begin
            pre_d = {PRE_W{1'b0}};
            cnt_d = cnt_q + {{(PWM_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler and ramp counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= {PRE_W{1'b0}};
            cnt_q <= {PWM_CNT_W{1'b0}};
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign pwm_bit = (cnt_q < duty);

endmodule

// File: rtl/expander_core.sv
// Command decoder and register file of the SPI I/O expander: parses write
// (two-byte) and read (one-byte) commands and drives the static/PWM pins.
module expander_core
    import expander_pkg::*;
#(
    parameter int PWM_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       data_rdy,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_latch,
    output logic [7:0] out
);

    state_e     state_q;
    logic [3:0] addr_q;
    logic [7:0] out_reg_q;
    logic [7:0] mode_q;
    logic [7:0] duty_q;
    logic [7:0] cmdcnt_q;
    logic [7:0] scratch_q;
    logic [7:0] data_out_q;
    logic       latch_q;
    logic [7:0] pins_q;
    logic       ss_meta_q;
    logic       ss_sync_q;

    logic       pwm_bit_s;
    logic [7:0] rd_data_s;
    logic [7:0] pins_d;

    function automatic logic [7:0] read_reg(
        input logic [3:0] a,
        input logic [7:0] o,
        input logic [7:0] m,
        input logic [7:0] d,
        input logic [7:0] c,
        input logic [7:0] s
    );
        logic [7:0] r;
        case (a)
            ADDR_OUT:     r = o;
            ADDR_MODE:    r = m;
            ADDR_DUTY:    r = d;
            ADDR_CMDCNT:  r = c;
            ADDR_SCRATCH: r = s;
            default:      r = 8'h00;
        endcase
        return r;
    endfunction

    pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_q),
        .pwm_bit (pwm_bit_s)
    );

    // Read mux and per-pin static/PWM select
    always_comb begin
        rd_data_s = read_reg(data_in[3:0], out_reg_q, mode_q, duty_q, cmdcnt_q, scratch_q);
        pins_d    = (mode_q & {8{pwm_bit_s}}) | (~mode_q & out_reg_q);
    end

    // Command FSM, register file, ss synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 4'h0;
            out_reg_q  <= 8'h00;
            mode_q     <= 8'h00;
            duty_q     <= 8'h00;
            cmdcnt_q   <= 8'h00;
            scratch_q  <= 8'h00;
            data_out_q <= 8'h00;
            latch_q    <= 1'b0;
            pins_q     <= 8'h00;
            ss_meta_q  <= 1'b1;
            ss_sync_q  <= 1'b1;
        end else begin
            ss_meta_q <= ss;
            ss_sync_q <= ss_meta_q;
            pins_q    <= pins_d;
            latch_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (data_rdy) begin
                        if (data_in[RW_BIT]) begin
                            data_out_q <= rd_data_s;
                            latch_q    <= 1'b1;
                            cmdcnt_q   <= cmdcnt_q + 8'd1;
                        end else begin
                            addr_q  <= data_in[3:0];
                            state_q <= ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    // A byte arriving in the abort cycle wins over the abort
                    if (data_rdy) begin
                        case (addr_q)
                            ADDR_OUT:     out_reg_q <= data_in;
                            ADDR_MODE:    mode_q    <= data_in;
                            ADDR_DUTY:    duty_q    <= data_in;
                            ADDR_SCRATCH: scratch_q <= data_in;
                            default:      ;
                        endcase
                        cmdcnt_q <= cmdcnt_q + 8'd1;
                        state_q  <= ST_IDLE;
                    end else if (ss_sync_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_latch = latch_q;
    assign out        = pins_q;

endmodule

// File: tb/tb_expander_core.sv
// Scoreboard bench for expander_core: stimulus pushes expected read responses,
// an independent monitor pops and checks them on every data_latch pulse.
module tb_expander_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b0;
    logic       data_rdy = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_latch;
    logic [7:0] out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    expander_core #(.PWM_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .data_rdy   (data_rdy),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_latch (data_latch),
        .out        (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every latch pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (data_latch === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_latch: got data_out 0x%0h at cycle %0d, expected no latch",
                         data_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_data"}, 32'(data_out), 32'(e.data));
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        data_in  = b;
        data_rdy = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        data_rdy = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b);
        idle();
    endtask

    task automatic push_exp(input string nm, input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_rd(input string nm, input logic [7:0] cmd, input logic [7:0] d);
        drive(cmd);
        push_exp(nm, d);
        idle();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        data_rdy = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int other_bad;

        // Reset state and CMDCNT after reset
        do_reset(2);
        @(negedge clk);
        check("rst_out", 32'(out), 32'h00);
        check("rst_latch", 32'(data_latch), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h00);
        wait_cycles(3);
        expect_rd("rst_cmdcnt", 8'h83, 8'h00);

        // Write OUT, check pin latency, read back, CMDCNT
        do_reset(2);
        wait_cycles(3);
        send(8'h00);
        drive(8'hA5);
        idle();
        @(negedge clk);
        check("out_t1_old", 32'(out), 32'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("out_t2_new", 32'(out), 32'hA5);
        expect_rd("rd_out", 8'h80, 8'hA5);
        expect_rd("rd_cnt2", 8'h83, 8'h02);

        // Reads on adjacent cycles
        drive(8'h84);
        push_exp("b2b_scratch", 8'h00);
        drive(8'h83);
        push_exp("b2b_cnt", 8'h04);
        idle();

        // PWM: DUTY 0x40 on pin 1, others static
        send(8'h02);
        send(8'h40);
        send(8'h01);
        send(8'h02);
        wait_cycles(4);
        hi = 0;
        other_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out[1] === 1'b1) hi++;
            if ((out & 8'hFD) !== 8'hA5) other_bad++;
        end
        check("pwm_high_count", hi, 64);
        check("pwm_static_pins", other_bad, 0);

        // Abort a pending write by raising ss
        send(8'h04);
        @(posedge clk);
        #1;
        ss = 1'b1;
        wait_cycles(4);
        ss = 1'b0;
        wait_cycles(4);
        expect_rd("abort_scratch", 8'h84, 8'h00);
        expect_rd("abort_cnt", 8'h83, 8'h08);

        // Read response in flight while a write command arrives
        drive(8'h80);
        push_exp("inflight_rd", 8'hA5);
        drive(8'h04);
        idle();
        send(8'h3C);
        expect_rd("inflight_scratch", 8'h84, 8'h3C);
        expect_rd("inflight_cnt", 8'h83, 8'h0C);

        // Unmapped / read-only addresses
        send(8'h09);
        send(8'h55);
        expect_rd("rd_addr9", 8'h89, 8'h00);
        expect_rd("rd_addrF", 8'h8F, 8'h00);
        expect_rd("rd_out_kept", 8'h80, 8'hA5);
        expect_rd("rd_scratch_kept", 8'h84, 8'h3C);
        send(8'h03);
        send(8'h77);
        expect_rd("cnt_after_ro_wr", 8'h83, 8'h13);

        // Reset while in WDATA, with a read arriving in the reset cycle
        send(8'h01);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        data_in  = 8'h80;
        data_rdy = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        data_rdy = 1'b0;
        @(negedge clk);
        check("rst_mid_out", 32'(out), 32'h00);
        check("rst_mid_data_out", 32'(data_out), 32'h00);
        expect_rd("post_rst_addrF", 8'hFF, 8'h00);
        expect_rd("post_rst_mode", 8'h81, 8'h00);
        expect_rd("post_rst_cnt", 8'h83, 8'h02);

        // Drain: every pushed response must have been seen
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_responses", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
